// File: rtl/resonator_dds_div_32s_16s_16_seq.sv
// Sequential signed restoring divider: 32-bit signed dividend / 16-bit signed
// divisor -> saturated 16-bit signed quotient and 16-bit signed remainder.
// One quotient bit per enabled clock, valid/ready on both sides.
//
// Handshake: an input transfer happens on an enabled edge where
// in_valid && in_ready; an output transfer happens on an enabled edge where
// out_valid && out_ready. in_ready depends on state only; out_valid and the
// result fields hold steady until that output transfer.
module resonator_dds_div_32s_16s_16_seq #(
  parameter int DIVIDEND_WIDTH = 32,
  parameter int DIVISOR_WIDTH  = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      ce,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIVISOR_WIDTH-1:0]  quotient,
  output logic [DIVISOR_WIDTH-1:0]  remainder,
  output logic                      overflow,
  output logic                      div_by_zero,
  output logic [1:0]                state_dbg
);

  localparam int DW = DIVIDEND_WIDTH;
  localparam int VW = DIVISOR_WIDTH;
  localparam int CW = $clog2(DIVIDEND_WIDTH);

  // Largest positive / negative quotient magnitudes representable in VW bits.
  localparam logic [DW-1:0] POS_LIM = DW'((64'd1 << (VW - 1)) - 64'd1);
  localparam logic [DW-1:0] NEG_LIM = DW'(64'd1 << (VW - 1));
  localparam logic [VW-1:0] POS_SAT = {1'b0, {(VW-1){1'b1}}};
  localparam logic [VW-1:0] NEG_SAT = {1'b1, {(VW-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_FINAL = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] dvd_q, dvd_d;        // dividend magnitude, shifted out MSB first
  logic [VW-1:0] dvs_q, dvs_d;        // divisor magnitude
  logic [VW:0]   rem_q, rem_d;        // partial remainder (always < |divisor|)
  logic [DW-1:0] quo_q, quo_d;        // quotient magnitude
  logic [CW-1:0] cnt_q, cnt_d;        // remaining iterations minus one
  logic          neg_q, neg_d;        // quotient is negative
  logic          rem_neg_q, rem_neg_d;// dividend was negative
  logic          zero_q, zero_d;      // divisor was zero
  logic          out_valid_q, out_valid_d;
  logic [VW-1:0] quotient_q, quotient_d;
  logic [VW-1:0] remainder_q, remainder_d;
  logic          overflow_q, overflow_d;
  logic          dbz_q, dbz_d;

  logic [VW+1:0] shifted;
  logic          step_ge;
  logic [VW-1:0] quo_lo;
  logic [VW-1:0] rem_lo;

  // Next-state and datapath: one restoring step per enabled BUSY cycle,
  // sign/saturation in FINAL, output hold in DONE.
  always_comb begin
    state_d     = state_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    neg_d       = neg_q;
    rem_neg_d   = rem_neg_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    overflow_d  = overflow_q;
    dbz_d       = dbz_q;

    shifted = {rem_q, dvd_q[DW-1]};
    step_ge = (shifted >= {2'b00, dvs_q});
    quo_lo  = quo_q[VW-1:0];
    rem_lo  = rem_q[VW-1:0];

    if (ce) begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            dvd_d     = dividend[DW-1] ? -dividend : dividend;
            dvs_d     = divisor[VW-1] ? -divisor : divisor;
            rem_d     = '0;
            quo_d     = '0;
            cnt_d     = CW'(DW - 1);
            neg_d     = dividend[DW-1] ^ divisor[VW-1];
            rem_neg_d = dividend[DW-1];
            zero_d    = (divisor == '0);
            state_d   = S_BUSY;
          end
        end
        S_BUSY: begin
          rem_d = step_ge ? (VW+1)'(shifted - {2'b00, dvs_q}) : (VW+1)'(shifted);
          quo_d = {quo_q[DW-2:0], step_ge};
          dvd_d = {dvd_q[DW-2:0], 1'b0};
          if (cnt_q == '0) begin
            state_d = S_FINAL;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        S_FINAL: begin
          overflow_d = 1'b0;
          dbz_d      = 1'b0;
          if (zero_q) begin
            quotient_d  = rem_neg_q ? NEG_SAT : POS_SAT;
            remainder_d = '0;
            dbz_d       = 1'b1;
          end else begin
            if (!neg_q) begin
              if (quo_q > POS_LIM) begin
                quotient_d = POS_SAT;
                overflow_d = 1'b1;
              end else begin
                quotient_d = quo_lo;
              end
            end else begin
              if (quo_q > NEG_LIM) begin
                quotient_d = NEG_SAT;
                overflow_d = 1'b1;
              end else begin
                quotient_d = -quo_lo;
              end
            end
            // A zero magnitude negates to zero, so no special case is needed.
            remainder_d = rem_neg_q ? -rem_lo : rem_lo;
          end
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and result registers; reset aborts any division in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      rem_neg_q   <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      overflow_q  <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
      rem_neg_q   <= rem_neg_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      overflow_q  <= overflow_d;
      dbz_q       <= dbz_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign overflow    = overflow_q;
  assign div_by_zero = dbz_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_resonator_dds_div_32s_16s_16_seq.sv
// Self-checking bench for the sequential signed divider.
module tb_resonator_dds_div_32s_16s_16_seq;

  logic        clk;
  logic        reset_n;
  logic        ce;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        overflow;
  logic        div_by_zero;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  resonator_dds_div_32s_16s_16_seq dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ce         (ce),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .overflow   (overflow),
    .div_by_zero(div_by_zero),
    .state_dbg  (state_dbg)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer division, truncate toward zero, then saturate.
  // Returns {quotient, remainder, overflow, div_by_zero}.
  function automatic logic [33:0] ref_div(input logic [31:0] a, input logic [15:0] b);
    longint la, lb, lq, lr;
    logic [15:0] q, r;
    logic ov, dz;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    ov = 1'b0;
    dz = 1'b0;
    if (lb == 0) begin
      dz = 1'b1;
      r  = 16'h0000;
      q  = (la < 0) ? 16'h8000 : 16'h7fff;
    end else begin
      lq = la / lb;
      lr = la % lb;
      if (lq > 32767) begin
        q = 16'h7fff; ov = 1'b1;
      end else if (lq < -32768) begin
        q = 16'h8000; ov = 1'b1;
      end else begin
        q = lq[15:0];
      end
      r = lr[15:0];
    end
    return {q, r, ov, dz};
  endfunction

  // Driver: present one operation, then count edges until out_valid.
  // nstall ce-low cycles are scattered over the BUSY window.
  task automatic run_op(input logic [31:0] a, input logic [15:0] b, input int nstall,
                        output int lat, output int acc_cyc);
    bit stall[0:255];
    int placed;
    int idx;
    int t;
    foreach (stall[i]) stall[i] = 1'b0;
    placed = 0;
    while (placed < nstall) begin
      idx = $urandom_range(3, 28);
      if (!stall[idx]) begin
        stall[idx] = 1'b1;
        placed++;
      end
    end
    t = 0;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_wait: in_ready=%0b required 1 within 100 cycles", in_ready);
    end
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk); #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = 16'($urandom);
    lat = 0;
    for (int k = 1; k <= 200; k++) begin
      ce = !stall[k];
      @(posedge clk); #1;
      ce = 1'b1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) begin
      checks++; errors++;
      $display("FAIL result_wait: out_valid=%0b required 1 within 200 cycles", out_valid);
    end
  endtask

  // Driver: accept the current result.
  task automatic pop_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ce = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, quotient, remainder, overflow, div_by_zero} !== {1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: rdy=%0b vld=%0b q=%h r=%h ov=%0b dz=%0b required rdy=1 vld=0 rest 0",
               in_ready, out_valid, quotient, remainder, overflow, div_by_zero);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: in_ready=%0b required 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [31:0] ta [8];
    logic [15:0] tb_ [8];
    logic [15:0] eq [8];
    logic [15:0] er [8];
    logic        eov [8];
    logic        edz [8];
    int lat, acc;
    ta = '{32'd1000, -32'sd1000, 32'd1000, 32'h7fffffff, 32'h80000000, -32'sd65536, 32'd5, -32'sd5};
    tb_ = '{16'd7, 16'd7, -16'sd7, 16'd1, 16'hffff, 16'd2, 16'd0, 16'd0};
    eq = '{16'd142, -16'sd142, -16'sd142, 16'h7fff, 16'h7fff, 16'h8000, 16'h7fff, 16'h8000};
    er = '{16'd6, -16'sd6, 16'd6, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    eov = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    edz = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      run_op(ta[i], tb_[i], 0, lat, acc);
      checks++;
      if (quotient !== eq[i]) begin
        errors++;
        $display("FAIL dir%0d_quotient: got %h required %h", i, quotient, eq[i]);
      end
      checks++;
      if (remainder !== er[i]) begin
        errors++;
        $display("FAIL dir%0d_remainder: got %h required %h", i, remainder, er[i]);
      end
      checks++;
      if ({overflow, div_by_zero} !== {eov[i], edz[i]}) begin
        errors++;
        $display("FAIL dir%0d_flags: got ov=%0b dz=%0b required ov=%0b dz=%0b",
                 i, overflow, div_by_zero, eov[i], edz[i]);
      end
      checks++;
      if (lat !== 33) begin
        errors++;
        $display("FAIL dir%0d_latency: got %0d required 33", i, lat);
      end
      pop_out();
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] q0, r0;
    logic ov0, dz0;
    int lat, acc;
    run_op(32'd123456, 16'd77, 0, lat, acc);
    q0 = quotient; r0 = remainder; ov0 = overflow; dz0 = div_by_zero;
    checks++;
    if ({q0, r0, ov0, dz0} !== ref_div(32'd123456, 16'd77)) begin
      errors++;
      $display("FAIL bp_result: got q=%h r=%h required %h", q0, r0, ref_div(32'd123456, 16'd77));
    end
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, quotient, remainder, overflow, div_by_zero} !== {1'b1, 1'b0, q0, r0, ov0, dz0}) begin
        errors++;
        $display("FAIL bp_hold_%0d: vld=%0b rdy=%0b q=%h r=%h required vld=1 rdy=0 q=%h r=%h",
                 k, out_valid, in_ready, quotient, remainder, q0, r0);
      end
    end
    pop_out();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp_release: vld=%0b rdy=%0b required vld=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_ce_stall();
    logic [31:0] a;
    logic [15:0] b;
    int lat, acc;
    a = 32'd987654;
    b = 16'($urandom_range(1, 30000));
    run_op(a, b, 5, lat, acc);
    checks++;
    if (lat !== 38) begin
      errors++;
      $display("FAIL stall_latency: got %0d required 38", lat);
    end
    checks++;
    if ({quotient, remainder, overflow, div_by_zero} !== ref_div(a, b)) begin
      errors++;
      $display("FAIL stall_result: got q=%h r=%h ov=%0b dz=%0b required %h",
               quotient, remainder, overflow, div_by_zero, ref_div(a, b));
    end
    pop_out();
  endtask

  task automatic test_abort();
    int lat, acc;
    run_op(32'd1000, 16'd7, 0, lat, acc);
    pop_out();
    in_valid = 1'b1; dividend = -32'sd1000; divisor = 16'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, quotient, remainder, overflow, div_by_zero} !== {1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL abort_state: rdy=%0b vld=%0b q=%h r=%h ov=%0b dz=%0b required rdy=1 vld=0 rest 0",
               in_ready, out_valid, quotient, remainder, overflow, div_by_zero);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_op(32'd100, 16'd3, 0, lat, acc);
    checks++;
    if ({quotient, remainder, overflow, div_by_zero} !== {16'd33, 16'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL abort_next_result: got q=%0d r=%0d ov=%0b dz=%0b required q=33 r=1 ov=0 dz=0",
               quotient, remainder, overflow, div_by_zero);
    end
    checks++;
    if (lat !== 33) begin
      errors++;
      $display("FAIL abort_next_latency: got %0d required 33", lat);
    end
    pop_out();
  endtask

  task automatic test_back_to_back();
    int lat_a, lat_b, acc_a, acc_b;
    logic [31:0] a0, a1;
    logic [15:0] b0, b1;
    a0 = $urandom; b0 = 16'($urandom_range(1, 65535));
    a1 = 32'($urandom_range(0, 1000000)); b1 = 16'($urandom_range(40, 900));
    out_ready = 1'b1;
    run_op(a0, b0, 0, lat_a, acc_a);
    checks++;
    if ({quotient, remainder, overflow, div_by_zero} !== ref_div(a0, b0)) begin
      errors++;
      $display("FAIL b2b_first_result: got q=%h r=%h required %h", quotient, remainder, ref_div(a0, b0));
    end
    checks++;
    if (lat_a !== 33) begin
      errors++;
      $display("FAIL b2b_early_ready_latency: got %0d required 33", lat_a);
    end
    run_op(a1, b1, 0, lat_b, acc_b);
    checks++;
    if (acc_b - acc_a !== 35) begin
      errors++;
      $display("FAIL b2b_interval: got %0d required 35", acc_b - acc_a);
    end
    checks++;
    if ({quotient, remainder, overflow, div_by_zero} !== ref_div(a1, b1)) begin
      errors++;
      $display("FAIL b2b_second_result: got q=%h r=%h required %h", quotient, remainder, ref_div(a1, b1));
    end
    pop_out();
  endtask

  task automatic test_random(input int n);
    logic [31:0] a;
    logic [15:0] b;
    logic [31:0] a_edge [6];
    logic [15:0] b_edge [5];
    int lat, acc, ns;
    a_edge = '{32'h80000000, 32'h7fffffff, 32'h0, 32'h1, 32'hffffffff, 32'hffff8000};
    b_edge = '{16'h0, 16'h1, 16'hffff, 16'h8000, 16'h7fff};
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 3))
        0: a = $urandom;
        1: a = 32'($urandom_range(0, 4000000)) - 32'd2000000;
        2: a = 32'($urandom_range(0, 2097152)) - 32'd1048576;
        default: a = a_edge[$urandom_range(0, 5)];
      endcase
      case ($urandom_range(0, 3))
        0: b = 16'($urandom);
        1: b = 16'($urandom_range(1, 300));
        2: b = -16'($urandom_range(1, 300));
        default: b = b_edge[$urandom_range(0, 4)];
      endcase
      ns = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      run_op(a, b, ns, lat, acc);
      checks++;
      if ({quotient, remainder, overflow, div_by_zero} !== ref_div(a, b)) begin
        errors++;
        $display("FAIL rand%0d_result: %h/%h got q=%h r=%h ov=%0b dz=%0b required %h",
                 i, a, b, quotient, remainder, overflow, div_by_zero, ref_div(a, b));
      end
      checks++;
      if (lat !== 33 + ns) begin
        errors++;
        $display("FAIL rand%0d_latency: got %0d required %0d", i, lat, 33 + ns);
      end
      pop_out();
    end
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_ce_stall();
    test_abort();
    test_back_to_back();
    test_random(1000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
